io_hub_bus: RTL and testbench
=============================

Name: io_hub_bus

Overview:
- Parametrised successor to the single-cycle IO hub. It decodes the CPU data port into RAM or IO and serves up to NSLOT peripheral slots over a registered request/ack bus.
- Slow peripherals stall the CPU; a per-access timeout prevents lockup, and timeouts are logged in a sticky error register.
- It also aggregates masked slot interrupts into a single CPU IRQ.
- Sits between the CPU data port, data RAM and all PIO/SEG/timer peripherals.

Parameters:
- NSLOT, 4, number of peripheral slots (1..15); slot index is addr[27:24].
- TIMEOUT, 255, ACCESS cycles allowed before a bus error (2..65535).
- IO_NIB, 4'hF, value of addr[31:28] that selects IO space.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- addr  input  32  CPU data address.
- datain  input  32  CPU store data.
- we  input  1  CPU store strobe.
- re  input  1  CPU load strobe.
- memout  input  32  data RAM read data.
- dataout  output  32  load data to CPU.
- wmem  output  1  RAM write enable.
- stall  output  1  freezes the CPU while an IO slot access is in flight.
- irq  output  1  registered OR of masked slot interrupts.
- slot_sel  output  NSLOT  one-hot slot select.
- slot_we  output  1  write qualifier for the selected slot.
- slot_addr  output  8  latched addr[7:0].
- slot_wdata  output  32  latched datain.
- slot_rdata  input  32*NSLOT  slot read data; slot k occupies bits [32k+31:32k].
- slot_ack  input  NSLOT  completion pulse from each slot.
- slot_irq  input  NSLOT  level interrupt requests.

Behaviour:
- Address decode:
  - io = (addr[31:28]==IO_NIB) & (we|re).
  - Memory path is combinational: wmem = we & ~io; dataout = memout when not IO.
- IO targets:
  - Slot s = addr[27:24]. s<NSLOT is a peripheral slot; s==4'hF is the hub register file; anything else is unmapped.
- FSM states are IDLE, ACCESS, DONE.
- IDLE:
  - Peripheral slot access: stall=1 combinationally. Latch s, we, addr[7:0] and datain; clear the counter; go to ACCESS.
  - Unmapped access: stall=1; set err and err_slot=s; rdata_q=0; go to DONE.
  - Hub-register access: no stall, single cycle. Read is combinational; write takes effect at the clock edge.
- ACCESS:
  - slot_sel[s_q]=1, slot_we=we_q, stall=1, counter increments each cycle.
  - slot_ack[s_q] seen: rdata_q <= slot_rdata[s_q], or 0 for a write. Go to DONE.
  - counter==TIMEOUT-1 with no ack: set err, err_slot=s_q, rdata_q=32'hDEADBEEF. Go to DONE; a write is dropped.
  - Acks from unselected slots are ignored.
- DONE:
  - stall=0, slot_sel=0, dataout=rdata_q; the CPU retires the instruction this cycle.
  - Next state is IDLE unconditionally. A new IO access in the following cycle starts fresh.
- Timing:
  - Ack in the first ACCESS cycle gives 2 stalled cycles, with data in cycle 3.
  - Timeout gives TIMEOUT+1 stalled cycles.
  - The CPU holds addr/we/re/datain stable while stall=1.
- Hub registers (offset addr[7:0]):
  - 0x00 STATUS: bit0 err (sticky; W1C when written with bit0=1), bits[7:4] err_slot, others 0. A later error overwrites err_slot.
  - 0x04 PEND: slot_irq & mask, read-only.
  - 0x08 MASK: NSLOT bits, read/write.
  - Other offsets read 0; writes to them are ignored.
- irq <= |(slot_irq & mask) every cycle, giving 1 cycle of latency.
- Error set (ACCESS/IDLE-unmapped) and W1C clear (IDLE hub write) cannot coincide, because the access is single-ported.
- Reset values (async, any state including mid-ACCESS):
  - state=IDLE; slot_sel=0, slot_we=0; slot_addr, slot_wdata, rdata_q, counter = 0; err=0, err_slot=0, mask=0, irq=0.
  - A slot that was mid-transaction must tolerate the select dropping.

Test Plan:
- RAM passthrough: store 0x12345678 to 0x00000010, then load → wmem=1 on the store, stall never asserts, dataout=memout.
- Slot read, NSLOT=4: load 0xF2000004 with slot 2 acking 3 cycles after select, slot_rdata[95:64]=0x000003A5 → slot_sel=4'b0100, slot_addr=0x04, stall high 4 cycles, dataout=0x000003A5 in DONE.
- Slot write: store 0x00FFFFFF to 0xF0000000 with slot 0 acking immediately → slot_we=1, slot_wdata=0x00FFFFFF for 1 cycle, stall 2 cycles.
- Timeout, TIMEOUT=8: load 0xF1000000 with slot 1 never acking → stall 9 cycles, dataout=0xDEADBEEF. STATUS read=0x11; write 0x1 to 0xFF000000, then STATUS=0x10.
- Unmapped and IRQ:
  - Load 0xF7000000 → dataout=0, STATUS bit0=1, err_slot=7.
  - Set MASK=4'b0010, drive slot_irq=4'b0011 → irq=1 one cycle later, PEND=0x2.
  - Clear mask → irq=0 one cycle later.
- Reset mid-ACCESS: assert resetn=0 in cycle 2 of a slot-3 read → slot_sel=0, stall=0, STATUS=0, MASK=0 immediately. After release the next IO access proceeds normally.

Source files
------------

// File: rtl/io_hub_bus.sv
// io_hub_bus: decodes the CPU data port into RAM or IO space. IO accesses go to one
// of NSLOT peripheral slots over a registered request/ack bus (with a per-access
// timeout), to a small hub register file, or are flagged as unmapped. Masked slot
// interrupts are folded into a single registered CPU IRQ.
module io_hub_bus #(
    parameter int unsigned NSLOT   = 4,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [3:0]  IO_NIB  = 4'hF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [31:0]           addr,
    input  logic [31:0]           datain,
    input  logic                  we,
    input  logic                  re,
    input  logic [31:0]           memout,
    output logic [31:0]           dataout,
    output logic                  wmem,
    output logic                  stall,
    output logic                  irq,
    output logic [NSLOT-1:0]      slot_sel,
    output logic                  slot_we,
    output logic [7:0]            slot_addr,
    output logic [31:0]           slot_wdata,
    input  logic [32*NSLOT-1:0]   slot_rdata,
    input  logic [NSLOT-1:0]      slot_ack,
    input  logic [NSLOT-1:0]      slot_irq
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

    state_t      state_q, state_d;
    logic [3:0]  s_q;
    logic        we_q;
    logic [15:0] cnt_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [3:0]  err_slot_q;
    logic [NSLOT-1:0] mask_q;

    logic [3:0]  s;
    logic        io, is_slot, is_hub;
    logic        sel_ack, timeout_hit, hub_wr;
    logic [31:0] sel_rdata, hub_rdata;

    // Address bits between the slot index and the register offset are not decoded.
    logic unused_addr;
    assign unused_addr = ^addr[23:8];

    assign s           = addr[27:24];
    assign io          = (addr[31:28] == IO_NIB) & (we | re);
    assign is_slot     = (32'(s) < NSLOT);
    assign is_hub      = (s == 4'hF);
    assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));
    assign hub_wr      = (state_q == StIdle) & io & is_hub & we;

    // Pick the ack and read data of the latched slot; other slots are ignored.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int unsigned k = 0; k < NSLOT; k++) begin
            if (s_q == 4'(k)) begin
                sel_ack   = slot_ack[k];
                sel_rdata = slot_rdata[32*k +: 32];
            end
        end
    end

    // Combinational hub register read.
    always_comb begin
        logic [31:0] mask_ext, pend_ext;
        mask_ext = '0;
        pend_ext = '0;
        mask_ext[NSLOT-1:0] = mask_q;
        pend_ext[NSLOT-1:0] = slot_irq & mask_q;
        case (addr[7:0])
            8'h00:   hub_rdata = {24'b0, err_slot_q, 3'b0, err_q};
            8'h04:   hub_rdata = pend_ext;
            8'h08:   hub_rdata = mask_ext;
            default: hub_rdata = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (io && !is_hub) state_d = is_slot ? StAccess : StDone;
            end
            StAccess: begin
                if (sel_ack || timeout_hit) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: slot bus control, CPU stall and load data mux.
    always_comb begin
        slot_sel = '0;
        slot_we  = 1'b0;
        stall    = 1'b0;
        wmem     = we & ~io;
        dataout  = memout;
        case (state_q)
            StIdle: begin
                stall = io & ~is_hub;
                if (io) dataout = is_hub ? hub_rdata : 32'h0;
            end
            StAccess: begin
                stall   = 1'b1;
                slot_we = we_q;
                for (int unsigned k = 0; k < NSLOT; k++) begin
                    if (s_q == 4'(k)) slot_sel[k] = 1'b1;
                end
                if (io) dataout = 32'h0;
            end
            StDone:  dataout = rdata_q;
            default: ;
        endcase
        // Keep the CPU free while the hub is held in reset.
        stall = stall & resetn;
    end

    // Datapath: request latch, access counter, response data and hub registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_q        <= '0;
            we_q       <= 1'b0;
            slot_addr  <= '0;
            slot_wdata <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_slot_q <= '0;
            mask_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (io && is_slot) begin
                        s_q        <= s;
                        we_q       <= we;
                        slot_addr  <= addr[7:0];
                        slot_wdata <= datain;
                        cnt_q      <= '0;
                    end else if (io && !is_hub) begin
                        err_q      <= 1'b1;
                        err_slot_q <= s;
                        rdata_q    <= '0;
                    end
                end
                StAccess: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (sel_ack) begin
                        rdata_q <= we_q ? 32'h0 : sel_rdata;
                    end else if (timeout_hit) begin
                        err_q      <= 1'b1;
                        err_slot_q <= s_q;
                        rdata_q    <= 32'hDEADBEEF;
                    end
                end
                default: ;
            endcase
            if (hub_wr) begin
                if (addr[7:0] == 8'h00 && datain[0]) err_q <= 1'b0;
                if (addr[7:0] == 8'h08) mask_q <= datain[NSLOT-1:0];
            end
        end
    end

    // Registered interrupt aggregation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) irq <= 1'b0;
        else         irq <= |(slot_irq & mask_q);
    end

endmodule

// File: tb/tb_io_hub_bus.sv
// Self-checking bench for io_hub_bus: directed scenarios plus randomized accesses,
// compared against a transaction-level model of the hub registers and latencies.
module tb_io_hub_bus;

    localparam int unsigned NSLOT   = 4;
    localparam int unsigned TIMEOUT = 8;

    logic         clk = 1'b0;
    logic         resetn;
    logic [31:0]  addr, datain, memout, dataout;
    logic         we, re, wmem, stall, irq, slot_we;
    logic [3:0]   slot_sel, slot_ack, slot_irq;
    logic [7:0]   slot_addr;
    logic [31:0]  slot_wdata;
    logic [127:0] slot_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic       m_err;
    logic [3:0] m_err_slot;
    logic [3:0] m_mask;

    io_hub_bus #(.NSLOT(NSLOT), .TIMEOUT(TIMEOUT), .IO_NIB(4'hF)) dut (
        .clk(clk), .resetn(resetn), .addr(addr), .datain(datain), .we(we), .re(re),
        .memout(memout), .dataout(dataout), .wmem(wmem), .stall(stall), .irq(irq),
        .slot_sel(slot_sel), .slot_we(slot_we), .slot_addr(slot_addr),
        .slot_wdata(slot_wdata), .slot_rdata(slot_rdata), .slot_ack(slot_ack),
        .slot_irq(slot_irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hub_model(input logic [7:0] off, input logic [3:0] irqv);
        case (off)
            8'h00:   return {24'b0, m_err_slot, 3'b0, m_err};
            8'h04:   return {28'b0, irqv & m_mask};
            8'h08:   return {28'b0, m_mask};
            default: return 32'h0;
        endcase
    endfunction

    // One CPU access preceded by an idle cycle that applies slot_irq = irqv.
    // delay: the ACCESS cycle (1-based) in which the target slot acks; >TIMEOUT = never.
    task automatic do_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input int delay, input logic [31:0] rd, input logic [3:0] irqv);
        logic [3:0]  s;
        logic        io_a, slot_a, hub_a;
        int          exp_stall, n;
        logic [31:0] exp_data;
        logic [3:0]  onehot;
        logic [31:0] lanes [4];
        bit          done;
        s      = a[27:24];
        io_a   = (a[31:28] == 4'hF);
        slot_a = io_a && (s < 4);
        hub_a  = io_a && (s == 4'hF);
        we = 1'b0; re = 1'b0; slot_ack = '0; slot_irq = irqv;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) lanes[i] = $urandom;
        if (slot_a) lanes[s[1:0]] = rd;
        slot_rdata = {lanes[3], lanes[2], lanes[1], lanes[0]};
        memout = $urandom;
        onehot = slot_a ? (4'b0001 << s) : 4'b0000;
        if (!io_a) begin
            exp_stall = 0; exp_data = memout;
        end else if (slot_a) begin
            if (delay <= int'(TIMEOUT)) begin
                exp_stall = delay + 1; exp_data = w ? 32'h0 : rd;
            end else begin
                exp_stall = TIMEOUT + 1; exp_data = 32'hDEADBEEF;
            end
        end else if (hub_a) begin
            exp_stall = 0; exp_data = hub_model(a[7:0], irqv);
        end else begin
            exp_stall = 1; exp_data = 32'h0;
        end
        addr = a; datain = d; we = w; re = !w;
        n = 0; done = 0;
        for (int c = 0; c < int'(TIMEOUT) + 20 && !done; c++) begin
            @(negedge clk);
            slot_ack = 4'($urandom) & ~onehot;
            if (stall) begin
                n++;
                if (slot_a && n == 2) begin
                    check_eq("slot_sel", 32'(slot_sel), 32'(onehot));
                    check_eq("slot_we", 32'(slot_we), 32'(w));
                    check_eq("slot_addr", 32'(slot_addr), 32'(a[7:0]));
                    check_eq("slot_wdata", slot_wdata, d);
                end
                if (slot_a && n == delay + 1) slot_ack = slot_ack | onehot;
            end else begin
                done = 1;
                check_eq("stall_cycles", 32'(n), 32'(exp_stall));
                if (!(hub_a && w)) check_eq("dataout", dataout, exp_data);
                check_eq("wmem", 32'(wmem), 32'(w && !io_a));
                check_eq("irq", 32'(irq), 32'(|(irqv & m_mask)));
            end
        end
        if (!done) check_eq("stall_bound", 32'(n), 32'(exp_stall));
        if ((slot_a && delay > int'(TIMEOUT)) || (io_a && !slot_a && !hub_a)) begin
            m_err = 1'b1; m_err_slot = s;
        end
        if (hub_a && w) begin
            if (a[7:0] == 8'h00 && d[0]) m_err = 1'b0;
            if (a[7:0] == 8'h08) m_mask = d[3:0];
        end
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0; slot_ack = '0;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  sl;
        logic [7:0]  off;
        int          kind;
        resetn = 1'b0; addr = '0; datain = '0; we = 1'b0; re = 1'b0; memout = '0;
        slot_rdata = '0; slot_ack = '0; slot_irq = '0;
        m_err = 1'b0; m_err_slot = '0; m_mask = '0;
        #3;
        check_eq("rst_slot_sel", 32'(slot_sel), 32'h0);
        check_eq("rst_stall", 32'(stall), 32'h0);
        check_eq("rst_irq", 32'(irq), 32'h0);
        check_eq("rst_slot_addr", 32'(slot_addr), 32'h0);
        check_eq("rst_slot_wdata", slot_wdata, 32'h0);
        addr = 32'hFF000000; re = 1'b1; #1;
        check_eq("rst_status", dataout, 32'h0);
        re = 1'b0;
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios
        do_access(32'h00000010, 1'b1, 32'h12345678, 0, 32'h0, 4'h0);
        do_access(32'h00000010, 1'b0, 32'h0, 0, 32'h0, 4'h0);
        do_access(32'hF2000004, 1'b0, 32'h0, 3, 32'h000003A5, 4'h0);
        do_access(32'hF0000000, 1'b1, 32'h00FFFFFF, 1, 32'h0, 4'h0);
        do_access(32'hF1000000, 1'b0, 32'h0, 100, 32'h0, 4'h0);
        do_access(32'hFF000000, 1'b0, 32'h0, 0, 32'h0, 4'h0);
        do_access(32'hFF000000, 1'b1, 32'h1, 0, 32'h0, 4'h0);
        do_access(32'hFF000000, 1'b0, 32'h0, 0, 32'h0, 4'h0);
        do_access(32'hF7000000, 1'b0, 32'h0, 0, 32'h0, 4'h0);
        do_access(32'hFF000000, 1'b0, 32'h0, 0, 32'h0, 4'h0);
        do_access(32'hFF000008, 1'b1, 32'h2, 0, 32'h0, 4'h3);
        do_access(32'hFF000004, 1'b0, 32'h0, 0, 32'h0, 4'h3);
        do_access(32'hFF000008, 1'b1, 32'h0, 0, 32'h0, 4'h3);
        do_access(32'hFF000008, 1'b0, 32'h0, 0, 32'h0, 4'h3);
        do_access(32'hF3000010, 1'b0, 32'h0, int'(TIMEOUT), 32'hCAFE0001, 4'h0);

        // Randomized accesses
        for (int it = 0; it < 200; it++) begin
            kind = $urandom_range(0, 5);
            d    = $urandom;
            sl   = 4'($urandom_range(0, 3));
            off  = 8'($urandom);
            case (kind)
                0: begin
                    a = $urandom; a[31:28] = 4'($urandom_range(0, 14));
                    do_access(a, 1'($urandom), d, 0, 32'h0, 4'($urandom));
                end
                1, 2: do_access({4'hF, sl, 16'h0, off}, 1'($urandom), d,
                                $urandom_range(1, TIMEOUT + 2), $urandom, 4'($urandom));
                3: do_access({4'hF, 4'($urandom_range(4, 14)), 16'h0, off}, 1'($urandom), d,
                             0, 32'h0, 4'($urandom));
                4: begin
                    if ($urandom_range(0, 3) != 0) off = 8'($urandom_range(0, 2) * 4);
                    do_access({24'hFF0000, off}, 1'b0, 32'h0, 0, 32'h0, 4'($urandom));
                end
                default: begin
                    off = ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h00;
                    do_access({24'hFF0000, off}, 1'b1, d, 0, 32'h0, 4'($urandom));
                end
            endcase
        end

        // Make sure the mask is non-zero, then reset in the middle of a slot-3 read
        do_access(32'hFF000008, 1'b1, 32'hF, 0, 32'h0, 4'h0);
        addr = 32'hF3000000; datain = '0; we = 1'b0; re = 1'b1; slot_ack = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("mid_sel", 32'(slot_sel), 32'h8);
        resetn = 1'b0; #1;
        check_eq("mid_rst_sel", 32'(slot_sel), 32'h0);
        check_eq("mid_rst_stall", 32'(stall), 32'h0);
        addr = 32'hFF000000; #1;
        check_eq("mid_rst_status", dataout, 32'h0);
        addr = 32'hFF000008; #1;
        check_eq("mid_rst_mask", dataout, 32'h0);
        m_err = 1'b0; m_err_slot = '0; m_mask = '0;
        re = 1'b0;
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        do_access(32'hF3000020, 1'b0, 32'h0, 2, 32'h5A5A1234, 4'h0);
        do_access(32'hFF000000, 1'b0, 32'h0, 0, 32'h0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
